aes_key_expand_128: RTL and testbench

- AES-128 key-schedule stage. Sits directly downstream of the round-constant generator and consumes its 32-bit rcon word every cycle.
- Expands a 128-bit cipher key into round keys 0..NR, one round key per clock, for the cipher round datapath.
- Shares the key-load strobe (kld) with the rcon generator, so both advance in lock-step.
- Instantiates four aes_sbox instances for SubWord.

---
 rtl/aes_key_expand_128.sv | 157 +++++++++++++++
 tb/tb_aes_key_expand_128.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_128.sv
// AES-128 key schedule stage.
// Produces one round key per clock from a loaded cipher key, using the
// round constant supplied each cycle by the upstream rcon generator.
// Also contains the combinational AES S-box used for SubWord.

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by
// the affine transform. Computed rather than tabulated to keep it compact.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] acc;
    p   = 8'h00;
    acc = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ acc;
      acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 (maps 0 to 0, which the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Affine transform over the inverse
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Substitution of one byte
  always_comb begin
    y = affine(gf_inv(a));
  end

endmodule

module aes_key_expand_128 #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kld,
  input  logic [127:0] key,
  input  logic [31:0]  rcon,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_EXPAND = 1'b1;

  localparam logic [3:0] NR_IDX = 4'(NR);

  logic        state_reg;
  logic [31:0] w0_reg, w1_reg, w2_reg, w3_reg;
  logic [31:0] w0_next, w1_next, w2_next, w3_next;
  logic [3:0]  idx_reg;
  logic        valid_reg;
  logic        busy_reg;
  logic        done_reg;

  logic [31:0] rot_w;
  logic [31:0] sub_w;
  logic [31:0] t_w;

  // Only the top byte of the round constant carries information
  logic unused_rcon_bits;
  assign unused_rcon_bits = ^rcon[23:0];

  // RotWord: left byte rotate of w3
  assign rot_w = {w3_reg[23:0], w3_reg[31:24]};

  // SubWord: one S-box per byte lane
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .a (rot_w[8*gi +: 8]),
        .y (sub_w[8*gi +: 8])
      );
    end
  endgenerate

  // Next round key; the words chain so all four update on the same edge
  always_comb begin
    t_w     = sub_w ^ {rcon[31:24], 24'h000000};
    w0_next = w0_reg ^ t_w;
    w1_next = w1_reg ^ w0_next;
    w2_next = w2_reg ^ w1_next;
    w3_next = w3_reg ^ w2_next;
  end

  // Load / expand / hold sequencing; kld always wins and restarts cleanly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      w0_reg    <= '0;
      w1_reg    <= '0;
      w2_reg    <= '0;
      w3_reg    <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (kld) begin
      state_reg <= ST_EXPAND;
      w0_reg    <= key[127:96];
      w1_reg    <= key[95:64];
      w2_reg    <= key[63:32];
      w3_reg    <= key[31:0];
      idx_reg   <= '0;
      valid_reg <= 1'b1;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else if (state_reg == ST_EXPAND) begin
      if (idx_reg < NR_IDX) begin
        w0_reg   <= w0_next;
        w1_reg   <= w1_next;
        w2_reg   <= w2_next;
        w3_reg   <= w3_next;
        idx_reg  <= idx_reg + 4'd1;
        done_reg <= ((idx_reg + 4'd1) == NR_IDX);
      end else begin
        // Final key has been shown for one cycle; park and hold it
        state_reg <= ST_IDLE;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b0;
      end
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign round_key = {w0_reg, w1_reg, w2_reg, w3_reg};
  assign round_idx = idx_reg;
  assign rk_valid  = valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Bench for aes_key_expand_128: known-answer round keys from FIPS-197,
// restart, async reset and a reduced-round (NR=4) build.
module tb_aes_key_expand_128;

  logic         clk;
  logic         rst_n;
  logic         kld;
  logic [127:0] key;
  logic [31:0]  rcon;

  logic [127:0] round_key, round_key4;
  logic [3:0]   round_idx, round_idx4;
  logic         rk_valid, rk_valid4;
  logic         busy, busy4;
  logic         done, done4;

  aes_key_expand_128 #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .kld(kld), .key(key), .rcon(rcon),
    .round_key(round_key), .round_idx(round_idx), .rk_valid(rk_valid),
    .busy(busy), .done(done)
  );

  aes_key_expand_128 #(.NR(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .kld(kld), .key(key), .rcon(rcon),
    .round_key(round_key4), .round_idx(round_idx4), .rk_valid(rk_valid4),
    .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle number (cycle after each rising edge)
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the upstream rcon generator, sharing kld
  int rc_cnt = 0;
  always @(posedge clk) begin
    if (kld) rc_cnt <= 1;
    else if (rc_cnt != 0 && rc_cnt < 11) rc_cnt <= rc_cnt + 1;
  end

  function automatic logic [7:0] rc_byte(input int n);
    case (n)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign rcon = {rc_byte(rc_cnt), 24'h000000};

  typedef struct {
    logic [127:0] key;
    int           rnd;
    logic [127:0] rk;
  } vec_t;

  typedef struct {
    int           cyc;
    bit           chk_rk;
    logic [127:0] rk;
    logic [3:0]   idx;
    logic         valid;
    logic         busy;
    logic         done;
  } exp_t;

  vec_t fips_tab[11];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KB_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] KB_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  task automatic push(input int c, input bit chk, input logic [127:0] rk,
                      input int idx, input logic v, input logic b, input logic d);
    exp_t e;
    e.cyc = c; e.chk_rk = chk; e.rk = rk; e.idx = 4'(idx);
    e.valid = v; e.busy = b; e.done = d;
    sb_q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare queued expectations in the cycle they are due
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL sb_stale: entry for cycle %0d not compared (now %0d)", e.cyc, cyc);
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      n_vec++;
      if ((e.chk_rk && round_key !== e.rk) || round_idx !== e.idx ||
          rk_valid !== e.valid || busy !== e.busy || done !== e.done) begin
        n_bad++;
        $display("FAIL sb cyc %0d: got rk=%h idx=%0d v=%b b=%b d=%b required rk=%h(chk=%0d) idx=%0d v=%b b=%b d=%b",
                 cyc, round_key, round_idx, rk_valid, busy, done,
                 e.rk, e.chk_rk, e.idx, e.valid, e.busy, e.done);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    fips_tab[0]  = '{KEY_A, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    fips_tab[1]  = '{KEY_A, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips_tab[2]  = '{KEY_A, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips_tab[3]  = '{KEY_A, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips_tab[4]  = '{KEY_A, 4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips_tab[5]  = '{KEY_A, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips_tab[6]  = '{KEY_A, 6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips_tab[7]  = '{KEY_A, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips_tab[8]  = '{KEY_A, 8,  128'head27321b58dbad2312bf5607f8d292f};
    fips_tab[9]  = '{KEY_A, 9,  128'hac7766f319fadc2128d12941575c006e};
    fips_tab[10] = '{KEY_A, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    rst_n = 1'b0;
    kld   = 1'b0;
    key   = '0;

    // Reset state, then idle with no kld
    tick;
    check("rst_rk", round_key, 128'h0);
    check("rst_flags", {125'h0, rk_valid, busy, done}, 128'h0);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) push(cyc + k, 1'b1, 128'h0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick;

    // Full expansion of the FIPS-197 key, then 20 cycles of hold
    c0  = cyc;
    key = fips_tab[0].key;
    kld = 1'b1;
    for (int r = 0; r <= 10; r++)
      push(c0 + 1 + r, 1'b1, fips_tab[r].rk, fips_tab[r].rnd, 1'b1, 1'b1, r == 10);
    for (int k = 12; k < 32; k++)
      push(c0 + k, 1'b1, fips_tab[10].rk, 10, 1'b1, 1'b0, 1'b0);
    tick;
    kld = 1'b0;
    while (cyc < c0 + 5) tick;
    @(negedge clk);
    check("nr4_rk", round_key4, fips_tab[4].rk);
    check("nr4_idx_done_busy", {121'h0, round_idx4, done4, busy4, rk_valid4},
          {121'h0, 4'd4, 1'b1, 1'b1, 1'b1});
    tick;
    @(negedge clk);
    check("nr4_hold_rk", round_key4, fips_tab[4].rk);
    check("nr4_hold_flags", {121'h0, round_idx4, done4, busy4, rk_valid4},
          {121'h0, 4'd4, 1'b0, 1'b0, 1'b1});
    while (cyc < c0 + 20) tick;
    @(negedge clk);
    check("nr4_hold_late", round_key4, fips_tab[4].rk);
    while (cyc < c0 + 32) tick;

    // Restart mid-expansion at round 4 with a second key
    c0  = cyc;
    key = KEY_A;
    kld = 1'b1;
    for (int r = 0; r <= 4; r++)
      push(c0 + 1 + r, 1'b1, fips_tab[r].rk, r, 1'b1, 1'b1, 1'b0);
    tick;
    kld = 1'b0;
    while (cyc < c0 + 5) tick;
    key = KEY_B;
    kld = 1'b1;
    push(c0 + 6, 1'b1, KEY_B, 0, 1'b1, 1'b1, 1'b0);
    push(c0 + 7, 1'b1, KB_R1, 1, 1'b1, 1'b1, 1'b0);
    for (int r = 2; r <= 9; r++) push(c0 + 6 + r, 1'b0, 128'h0, r, 1'b1, 1'b1, 1'b0);
    push(c0 + 16, 1'b1, KB_R10, 10, 1'b1, 1'b1, 1'b1);
    push(c0 + 17, 1'b1, KB_R10, 10, 1'b1, 1'b0, 1'b0);
    push(c0 + 18, 1'b1, KB_R10, 10, 1'b1, 1'b0, 1'b0);
    tick;
    kld = 1'b0;
    while (cyc < c0 + 19) tick;

    // Asynchronous reset between edges, mid-expansion
    c0  = cyc;
    key = KEY_B;
    kld = 1'b1;
    tick;
    kld = 1'b0;
    while (cyc < c0 + 3) tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rk", round_key, 128'h0);
    check("async_rst_flags", {123'h0, round_idx == 4'd0, rk_valid, busy, done, 1'b0},
          {123'h0, 1'b1, 4'h0});
    check("async_rst_nr4", {round_key4 ^ {124'h0, round_idx4}}, 128'h0);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) push(cyc + k, 1'b1, 128'h0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 13; k++) tick;

    // Everything queued must have been compared
    for (int k = 0; k < 5 && sb_q.size() > 0; k++) tick;
    if (sb_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
